// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register busy/tag scoreboard for a 4-wide in-order issue stage
module reg_scoreboard #(
  parameter int des       = 4,
  parameter int reg_num   = 16,
  parameter int branch_id = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_1_vld,
  input  logic                 in_1_wr,
  input  logic [des-1:0]       in_1_des,
  input  logic [des-1:0]       in_1_s1,
  input  logic [des-1:0]       in_1_s2,
  input  logic [branch_id-1:0] in_1_branch,
  input  logic                 in_2_vld,
  input  logic                 in_2_wr,
  input  logic [des-1:0]       in_2_des,
  input  logic [des-1:0]       in_2_s1,
  input  logic [des-1:0]       in_2_s2,
  input  logic [branch_id-1:0] in_2_branch,
  input  logic                 in_3_vld,
  input  logic                 in_3_wr,
  input  logic [des-1:0]       in_3_des,
  input  logic [des-1:0]       in_3_s1,
  input  logic [des-1:0]       in_3_s2,
  input  logic [branch_id-1:0] in_3_branch,
  input  logic                 in_4_vld,
  input  logic                 in_4_wr,
  input  logic [des-1:0]       in_4_des,
  input  logic [des-1:0]       in_4_s1,
  input  logic [des-1:0]       in_4_s2,
  input  logic [branch_id-1:0] in_4_branch,
  input  logic                 back_1_vld,
  input  logic [des-1:0]       back_1_des,
  input  logic                 back_2_vld,
  input  logic [des-1:0]       back_2_des,
  input  logic                 back_3_vld,
  input  logic [des-1:0]       back_3_des,
  input  logic                 back_4_vld,
  input  logic [des-1:0]       back_4_des,
  input  logic                 kill_vld,
  input  logic [branch_id-1:0] kill_bid,
  output logic                 grant_1,
  output logic                 grant_2,
  output logic                 grant_3,
  output logic                 grant_4,
  output logic                 stall,
  output logic [reg_num-1:0]   busy_vec,
  output logic [4:0]           pend_cnt
);

  logic [reg_num-1:0]   busy, busy_nxt;
  logic [branch_id-1:0] tag [reg_num];
  logic [branch_id-1:0] tag_nxt [reg_num];
  logic [4:0]           pend_nxt;

  logic [3:0]           vld, wr, gnt, bvld;
  logic [des-1:0]       dst [4];
  logic [des-1:0]       src1 [4];
  logic [des-1:0]       src2 [4];
  logic [des-1:0]       bdes [4];
  logic [branch_id-1:0] br [4];

  assign vld  = {in_4_vld, in_3_vld, in_2_vld, in_1_vld};
  assign wr   = {in_4_wr, in_3_wr, in_2_wr, in_1_wr};
  assign bvld = {back_4_vld, back_3_vld, back_2_vld, back_1_vld};
  assign dst[0]  = in_1_des;    assign dst[1]  = in_2_des;
  assign dst[2]  = in_3_des;    assign dst[3]  = in_4_des;
  assign src1[0] = in_1_s1;     assign src1[1] = in_2_s1;
  assign src1[2] = in_3_s1;     assign src1[3] = in_4_s1;
  assign src2[0] = in_1_s2;     assign src2[1] = in_2_s2;
  assign src2[2] = in_3_s2;     assign src2[3] = in_4_s2;
  assign br[0]   = in_1_branch; assign br[1]   = in_2_branch;
  assign br[2]   = in_3_branch; assign br[3]   = in_4_branch;
  assign bdes[0] = back_1_des;  assign bdes[1] = back_2_des;
  assign bdes[2] = back_3_des;  assign bdes[3] = back_4_des;

  function automatic logic busy_at(input logic [reg_num-1:0] bv, input logic [des-1:0] idx);
    return (int'(idx) < reg_num) && (idx != '0) && bv[idx];
  endfunction

  // Registered busy only: a writeback landing this cycle does not bypass into grants.
  always_comb begin
    logic haz;
    logic blk;
    gnt = '0;
    haz = 1'b0;
    blk = 1'b0;
    for (int k = 0; k < 4; k++) begin
      haz = busy_at(busy, src1[k]) | busy_at(busy, src2[k]) | (wr[k] & busy_at(busy, dst[k]));
      blk = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (gnt[j] && wr[j] && dst[j] != '0 &&
            (dst[j] == src1[k] || dst[j] == src2[k] || (wr[k] && dst[j] == dst[k])))
          haz = 1'b1;
        if (vld[j] && !gnt[j])
          blk = 1'b1;
      end
      gnt[k] = vld[k] & ~haz & ~blk & ~kill_vld & ~rst;
    end
  end

  assign grant_1 = gnt[0];
  assign grant_2 = gnt[1];
  assign grant_3 = gnt[2];
  assign grant_4 = gnt[3];
  assign stall   = |(vld & ~gnt);

  // Clears first, then issue sets override them; reset overrides everything.
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < reg_num; r++) begin
      tag_nxt[r] = tag[r];
      if (kill_vld && busy[r] && tag[r] == kill_bid)
        busy_nxt[r] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      if (bvld[k] && int'(bdes[k]) < reg_num)
        busy_nxt[bdes[k]] = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      if (gnt[k] && wr[k] && dst[k] != '0 && int'(dst[k]) < reg_num) begin
        busy_nxt[dst[k]] = 1'b1;
        tag_nxt[dst[k]]  = br[k];
      end
    end
    busy_nxt[0] = 1'b0;
    if (rst) begin
      busy_nxt = '0;
      for (int r = 0; r < reg_num; r++)
        tag_nxt[r] = '0;
    end
    pend_nxt = 5'($countones(busy_nxt));
  end

  always_ff @(posedge clk) begin
    busy     <= busy_nxt;
    pend_cnt <= pend_nxt;
    for (int r = 0; r < reg_num; r++)
      tag[r] <= tag_nxt[r];
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed stimulus with queued expectations checked by a monitor
module tb_reg_scoreboard;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] vld, wr, bvld;
  logic [3:0] dd [4];
  logic [3:0] s1 [4];
  logic [3:0] s2 [4];
  logic [2:0] br [4];
  logic [3:0] bd [4];
  logic       kill_vld;
  logic [2:0] kill_bid;
  logic       g1, g2, g3, g4, stall;
  logic [15:0] busy_vec;
  logic [4:0]  pend_cnt;

  typedef struct {
    logic [3:0]  gnt;
    logic        stall;
    logic [15:0] busy;
    logic [4:0]  pend;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst(rst),
    .in_1_vld(vld[0]), .in_1_wr(wr[0]), .in_1_des(dd[0]), .in_1_s1(s1[0]), .in_1_s2(s2[0]), .in_1_branch(br[0]),
    .in_2_vld(vld[1]), .in_2_wr(wr[1]), .in_2_des(dd[1]), .in_2_s1(s1[1]), .in_2_s2(s2[1]), .in_2_branch(br[1]),
    .in_3_vld(vld[2]), .in_3_wr(wr[2]), .in_3_des(dd[2]), .in_3_s1(s1[2]), .in_3_s2(s2[2]), .in_3_branch(br[2]),
    .in_4_vld(vld[3]), .in_4_wr(wr[3]), .in_4_des(dd[3]), .in_4_s1(s1[3]), .in_4_s2(s2[3]), .in_4_branch(br[3]),
    .back_1_vld(bvld[0]), .back_1_des(bd[0]),
    .back_2_vld(bvld[1]), .back_2_des(bd[1]),
    .back_3_vld(bvld[2]), .back_3_des(bd[2]),
    .back_4_vld(bvld[3]), .back_4_des(bd[3]),
    .kill_vld(kill_vld), .kill_bid(kill_bid),
    .grant_1(g1), .grant_2(g2), .grant_3(g3), .grant_4(g4),
    .stall(stall), .busy_vec(busy_vec), .pend_cnt(pend_cnt)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle after inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grants", int'({g4, g3, g2, g1}), int'(e.gnt));
        chk("stall", int'(stall), int'(e.stall));
        chk("busy_vec", int'(busy_vec), int'(e.busy));
        chk("pend_cnt", int'(pend_cnt), int'(e.pend));
      end
    end
  end

  task automatic clr();
    vld = '0; wr = '0; bvld = '0; kill_vld = 1'b0; kill_bid = '0;
    for (int i = 0; i < 4; i++) begin
      dd[i] = '0; s1[i] = '0; s2[i] = '0; br[i] = '0; bd[i] = '0;
    end
  endtask

  task automatic slot(input int k, input logic w, input logic [3:0] d,
                      input logic [3:0] a, input logic [3:0] b, input logic [2:0] t);
    vld[k-1] = 1'b1; wr[k-1] = w; dd[k-1] = d; s1[k-1] = a; s2[k-1] = b; br[k-1] = t;
  endtask

  task automatic back(input int k, input logic [3:0] d);
    bvld[k-1] = 1'b1; bd[k-1] = d;
  endtask

  task automatic step(input logic [3:0] g, input logic st, input logic [15:0] bz, input logic [4:0] pc);
    exp_t e;
    e.gnt = g; e.stall = st; e.busy = bz; e.pend = pc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wait_cyc;
    clr();
    rst = 1'b1;
    @(posedge clk); #1;
    // reset held with a valid slot: no grants, clean state
    slot(1, 1, 4'd3, 4'd1, 4'd2, 3'd0);
    step(4'b0000, 1'b1, 16'h0000, 5'd0);
    rst = 1'b0; clr();
    slot(1, 1, 4'd3, 4'd1, 4'd2, 3'd0);
    step(4'b0001, 1'b0, 16'h0000, 5'd0);
    clr(); slot(1, 0, 4'd0, 4'd3, 4'd0, 3'd0); back(1, 4'd3);
    step(4'b0000, 1'b1, 16'h0008, 5'd1);
    clr(); slot(1, 0, 4'd0, 4'd3, 4'd0, 3'd0);
    step(4'b0001, 1'b0, 16'h0000, 5'd0);
    clr(); slot(1, 1, 4'd5, 4'd0, 4'd0, 3'd0); slot(2, 0, 4'd0, 4'd0, 4'd5, 3'd0);
    slot(3, 0, 4'd0, 4'd7, 4'd0, 3'd0);
    step(4'b0001, 1'b1, 16'h0000, 5'd0);
    clr(); slot(1, 1, 4'd4, 4'd0, 4'd0, 3'd2); slot(2, 1, 4'd6, 4'd0, 4'd0, 3'd1); back(1, 4'd5);
    step(4'b0011, 1'b0, 16'h0020, 5'd1);
    clr(); kill_vld = 1'b1; kill_bid = 3'd2; slot(1, 0, 4'd0, 4'd1, 4'd0, 3'd0);
    step(4'b0000, 1'b1, 16'h0050, 5'd2);
    clr(); slot(1, 1, 4'd9, 4'd0, 4'd0, 3'd3);
    step(4'b0001, 1'b0, 16'h0040, 5'd1);
    // WAW on busy[9] blocks the slot; writeback still clears it
    clr(); slot(1, 1, 4'd9, 4'd0, 4'd0, 3'd5); back(2, 4'd9);
    step(4'b0000, 1'b1, 16'h0240, 5'd2);
    // issue set beats a same-edge writeback to the same register
    clr(); slot(1, 1, 4'd10, 4'd0, 4'd0, 3'd5); back(1, 4'd10);
    step(4'b0001, 1'b0, 16'h0040, 5'd1);
    clr(); kill_vld = 1'b1; kill_bid = 3'd5;
    step(4'b0000, 1'b0, 16'h0440, 5'd2);
    clr(); slot(1, 1, 4'd0, 4'd0, 4'd0, 3'd0); slot(2, 1, 4'd0, 4'd0, 4'd0, 3'd0);
    slot(4, 0, 4'd0, 4'd1, 4'd0, 3'd0); back(1, 4'd0);
    step(4'b1011, 1'b0, 16'h0040, 5'd1);
    clr(); rst = 1'b1; slot(1, 1, 4'd7, 4'd0, 4'd0, 3'd0);
    step(4'b0000, 1'b1, 16'h0040, 5'd1);
    clr(); rst = 1'b0;
    slot(1, 1, 4'd6, 4'd6, 4'd0, 3'd0); slot(2, 1, 4'd8, 4'd0, 4'd0, 3'd0);
    slot(3, 0, 4'd0, 4'd0, 4'd8, 3'd0);
    step(4'b0011, 1'b1, 16'h0000, 5'd0);
    clr(); slot(1, 0, 4'd0, 4'd1, 4'd0, 3'd0); slot(2, 0, 4'd0, 4'd2, 4'd0, 3'd0);
    slot(3, 0, 4'd0, 4'd3, 4'd0, 3'd0); slot(4, 0, 4'd0, 4'd4, 4'd0, 3'd0);
    step(4'b1111, 1'b0, 16'h0140, 5'd2);
    clr();
    step(4'b0000, 1'b0, 16'h0140, 5'd2);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
